aes_encipher_block: RTL and testbench

Iterative AES encipher datapath (FIPS-197), one round per clock, supporting AES-128 and AES-256. It is the forward-direction counterpart to the decipher path. Round keys come from the external key memory (key expansion block), indexed by this block's round output. It sits inside the core beside the decipher block; the core top muxes between the two on encdec.

---
 rtl/aes_pkg.sv | 43 ++++
 rtl/aes_sbox.sv | 32 +++
 rtl/aes_encipher_block.sv | 90 +++++++++
 tb/tb_aes_encipher_block.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, round counts and GF(2^8) round helpers
package aes_pkg;

  localparam logic [3:0] AES128_ROUNDS = 4'd10;
  localparam logic [3:0] AES256_ROUNDS = 4'd14;

  typedef enum logic [1:0] {IDLE, MAIN, FINAL} aes_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column bytes are {row0,row1,row2,row3}, row0 in the top byte.
  function automatic logic [31:0] mixcolumn(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mixcolumns(input logic [127:0] d);
    return {mixcolumn(d[127:96]), mixcolumn(d[95:64]),
            mixcolumn(d[63:32]), mixcolumn(d[31:0])};
  endfunction

  function automatic logic [127:0] shiftrows(input logic [127:0] d);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = d[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] addroundkey(input logic [127:0] d, input logic [127:0] k);
    return d ^ k;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational forward AES S-box
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  // Entry for input v lives at bits [2047-8v -: 8], i.e. row-major from 0x00.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] idx;

  assign idx = {~x, 3'b111};
  assign y   = SBOX_TABLE[idx -: 8];

endmodule

// File: rtl/aes_encipher_block.sv
// rtl/aes_encipher_block.sv - iterative AES-128/256 encipher, one round per clock
module aes_encipher_block
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready,
  output logic         result_valid
);

  aes_state_t   state, state_nxt;
  logic [127:0] state_reg;
  logic [127:0] sub_bytes, shifted, main_out, final_out;
  logic [3:0]   nr;
  logic         init_en, round_en, final_en;

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_sbox u_sbox (
      .x (state_reg[8*g +: 8]),
      .y (sub_bytes[8*g +: 8])
    );
  end

  assign shifted   = shiftrows(sub_bytes);
  assign main_out  = addroundkey(mixcolumns(shifted), round_key);
  assign final_out = addroundkey(shifted, round_key);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (next) state_nxt = MAIN;
      MAIN:    if (round + 4'd1 == nr) state_nxt = FINAL;
      FINAL:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    init_en  = 1'b0;
    round_en = 1'b0;
    final_en = 1'b0;
    case (state)
      IDLE:    init_en  = next;
      MAIN:    round_en = 1'b1;
      FINAL:   final_en = 1'b1;
      default: ;
    endcase
  end

  // round doubles as the key-memory index, so it must track the key in use.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= '0;
      round        <= 4'd0;
      nr           <= AES128_ROUNDS;
      new_block    <= '0;
      ready        <= 1'b1;
      result_valid <= 1'b0;
    end else if (init_en) begin
      nr           <= keylen ? AES256_ROUNDS : AES128_ROUNDS;
      state_reg    <= addroundkey(block, round_key);
      round        <= 4'd1;
      ready        <= 1'b0;
      result_valid <= 1'b0;
    end else if (round_en) begin
      state_reg    <= main_out;
      round        <= round + 4'd1;
    end else if (final_en) begin
      new_block    <= final_out;
      round        <= 4'd0;
      ready        <= 1'b1;
      result_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_encipher_block.sv
// tb/tb_aes_encipher_block.sv - scoreboard bench for aes_encipher_block against a byte-level AES model
module tb_aes_encipher_block;

  logic         clk;
  logic         reset_n;
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;
  logic         result_valid;

  aes_encipher_block dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .next         (next),
    .keylen       (keylen),
    .round        (round),
    .round_key    (round_key),
    .block        (block),
    .new_block    (new_block),
    .ready        (ready),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]   sbox_ref [256];
  logic [31:0]  w [60];
  logic [127:0] rk_mem [16];

  logic [127:0] sb_q [$];
  int           cyc_q [$];
  logic         prev_rv = 1'b0;
  logic [127:0] held = '0;

  assign round_key = rk_mem[round];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv, b;
      inv = 8'h00;
      for (int u = 1; u < 256; u++)
        if (v != 0 && gmul(8'(v), 8'(u)) == 8'h01) inv = 8'(u);
      b = inv;
      sbox_ref[v] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input bit kl);
    int nk, nr;
    logic [31:0] t;
    logic [7:0] rc;
    nk = kl ? 8 : 4;
    nr = kl ? 14 : 10;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk_mem[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  function automatic logic [127:0] model_enc(input logic [127:0] blk, input bit kl);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    int nr;
    nr = kl ? 14 : 10;
    for (int k = 0; k < 16; k++) s[k] = blk[127-8*k -: 8] ^ rk_mem[0][127-8*k -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int k = 0; k < 16; k++) t[k] = sbox_ref[s[k]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rd != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk_mem[rd][127-8*k -: 8];
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction

  // Called at a negedge; returns at a negedge.
  task automatic issue(input bit kl, input logic [127:0] blk, input logic [127:0] exp,
                       input bit toggle, input bit trace);
    int n, nr;
    nr = kl ? 14 : 10;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      chk("ready_timeout", {127'h0, ready}, 128'h1);
      return;
    end
    chk("idle_round", round, 128'h0);
    next = 1'b1;
    keylen = kl;
    block = blk;
    sb_q.push_back(exp);
    cyc_q.push_back(cyc + 1 + nr);
    @(negedge clk);
    next = 1'b0;
    chk("valid_drop", {127'h0, result_valid}, 128'h0);
    if (trace || toggle) begin
      for (int i = 1; i <= nr; i++) begin
        if (trace) begin
          chk("round_seq", round, 128'(i));
          chk("busy_ready", {127'h0, ready}, 128'h0);
        end
        if (toggle && i < nr - 1) begin
          next = 1'($urandom);
          keylen = 1'($urandom);
          block = {$urandom, $urandom, $urandom, $urandom};
        end else begin
          next = 1'b0;
        end
        @(negedge clk);
      end
      if (trace) begin
        chk("round_end", round, 128'h0);
        chk("done_ready", {127'h0, ready}, 128'h1);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 128'(sb_q.size()), 128'h0);
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_rv = 1'b0;
    end else begin
      if (result_valid && !prev_rv) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", new_block, 128'hx);
        end else begin
          chk("ciphertext", new_block, sb_q.pop_front());
          chk("latency", 128'(cyc), 128'(cyc_q.pop_front()));
        end
        held = new_block;
      end else if (result_valid) begin
        chk("hold", new_block, held);
      end
      prev_rv = result_valid;
    end
  end

  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] BLK_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BLK_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    int n;
    reset_n = 1'b1;
    next = 1'b0;
    keylen = 1'b0;
    block = '0;
    build_sbox();
    expand(KEY_B, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_ready", {127'h0, ready}, 128'h1);
    chk("rst_valid", {127'h0, result_valid}, 128'h0);
    chk("rst_new_block", new_block, 128'h0);
    chk("rst_round", round, 128'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    chk("model_b", model_enc(BLK_B, 1'b0), CT_B);
    issue(1'b0, BLK_B, CT_B, 1'b0, 1'b1);
    drain();

    expand(KEY_C1, 1'b0);
    chk("model_c1", model_enc(BLK_C, 1'b0), CT_C1);
    issue(1'b0, BLK_C, CT_C1, 1'b0, 1'b1);
    drain();

    expand(KEY_C3, 1'b1);
    chk("model_c3", model_enc(BLK_C, 1'b1), CT_C3);
    issue(1'b1, BLK_C, CT_C3, 1'b0, 1'b1);
    drain();

    expand(KEY_C1, 1'b0);
    issue(1'b0, BLK_C, CT_C1, 1'b1, 1'b0);
    chk("b2b_ready", {127'h0, ready}, 128'h1);
    issue(1'b0, BLK_C, CT_C1, 1'b0, 1'b1);
    drain();

    issue(1'b0, BLK_C, CT_C1, 1'b0, 1'b0);
    n = 0;
    while (round !== 4'd5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reach_round5", round, 128'h5);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_ready", {127'h0, ready}, 128'h1);
    chk("abort_valid", {127'h0, result_valid}, 128'h0);
    chk("abort_new_block", new_block, 128'h0);
    chk("abort_round", round, 128'h0);
    sb_q.delete();
    cyc_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue(1'b0, BLK_C, CT_C1, 1'b0, 1'b0);
    drain();

    for (int t = 0; t < 20; t++) begin
      bit kl, pair;
      logic [255:0] key;
      logic [127:0] blk;
      kl = 1'($urandom);
      pair = ($urandom_range(0, 9) < 3);
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      expand(key, kl);
      blk = {$urandom, $urandom, $urandom, $urandom};
      issue(kl, blk, model_enc(blk, kl), 1'($urandom), 1'b0);
      if (pair) begin
        blk = {$urandom, $urandom, $urandom, $urandom};
        issue(kl, blk, model_enc(blk, kl), 1'b0, 1'b0);
      end
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
